spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 130 +++++++++++++
 tb/tb_spi_slave.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI slave: receives {cmd[1:0], payload} frames on MOSI and returns a read byte on MISO.
// The system clock doubles as the serial bit clock; all state advances on its rising edge.
module spi_slave #(
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 MOSI,
    input  logic                 tx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    output logic                 MISO,
    output logic                 rx_valid,
    output logic [ADDR_SIZE+1:0] rx_data
);

    localparam int unsigned N     = ADDR_SIZE + 2;
    localparam int unsigned CNT_W = $clog2(N);

    localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(ADDR_SIZE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StChkCmd,
        StWrite,
        StReadAdd,
        StReadData
    } state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [N-2:0]           rx_shift_q;
    logic [ADDR_SIZE-2:0]   tx_shift_q;
    logic                   rd_addr_flag_q;
    // In StReadData: frame received (now waiting for / sending read data), and sending.
    logic                   rx_done_q;
    logic                   tx_busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            tx_shift_q     <= '0;
            rd_addr_flag_q <= 1'b0;
            rx_done_q      <= 1'b0;
            tx_busy_q      <= 1'b0;
            MISO           <= 1'b0;
            rx_valid       <= 1'b0;
            rx_data        <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (state_q != StIdle && SS_n) begin
                // Deselect drops any partial frame or transfer; the read-address flag survives.
                state_q    <= StIdle;
                bit_cnt_q  <= '0;
                rx_shift_q <= '0;
                tx_shift_q <= '0;
                rx_done_q  <= 1'b0;
                tx_busy_q  <= 1'b0;
                MISO       <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (!SS_n) begin
                            state_q <= StChkCmd;
                        end
                    end

                    StChkCmd: begin
                        bit_cnt_q <= '0;
                        if (!MOSI) begin
                            state_q <= StWrite;
                        end else if (rd_addr_flag_q) begin
                            state_q <= StReadData;
                        end else begin
                            state_q <= StReadAdd;
                        end
                    end

                    StWrite, StReadAdd, StReadData: begin
                        if (state_q != StReadData || !rx_done_q) begin
                            rx_shift_q <= {rx_shift_q[N-3:0], MOSI};
                            if (bit_cnt_q == LAST_RX) begin
                                rx_data   <= {rx_shift_q, MOSI};
                                rx_valid  <= 1'b1;
                                bit_cnt_q <= '0;
                                if (state_q == StReadData) begin
                                    rx_done_q <= 1'b1;
                                end else begin
                                    state_q <= StChkCmd;
                                    if (state_q == StReadAdd) begin
                                        rd_addr_flag_q <= 1'b1;
                                    end
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end else if (!tx_busy_q) begin
                            if (tx_valid) begin
                                tx_shift_q <= tx_data[ADDR_SIZE-2:0];
                                MISO       <= tx_data[ADDR_SIZE-1];
                                tx_busy_q  <= 1'b1;
                                bit_cnt_q  <= '0;
                            end
                        end else if (bit_cnt_q == LAST_TX) begin
                            // LSB has had its cycle on MISO; close out the read.
                            MISO           <= 1'b0;
                            tx_busy_q      <= 1'b0;
                            rx_done_q      <= 1'b0;
                            rd_addr_flag_q <= 1'b0;
                            bit_cnt_q      <= '0;
                            state_q        <= StChkCmd;
                        end else begin
                            MISO       <= tx_shift_q[ADDR_SIZE-2];
                            tx_shift_q <= tx_shift_q << 1;
                            bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                        end
                    end

                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed scenarios followed by randomized frame traffic,
// checked against a transaction-level model of the slave.
module tb_spi_slave;

    localparam int unsigned AS = 8;
    localparam int unsigned N  = AS + 2;

    logic          clk;
    logic          rst;
    logic          SS_n;
    logic          MOSI;
    logic          tx_valid;
    logic [AS-1:0] tx_data;
    logic          MISO;
    logic          rx_valid;
    logic [N-1:0]  rx_data;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model state: read-address flag and the last completed frame.
    logic          m_flag;
    logic [N-1:0]  m_rx;

    spi_slave #(
        .ADDR_SIZE(AS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .SS_n    (SS_n),
        .MOSI    (MOSI),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .MISO    (MISO),
        .rx_valid(rx_valid),
        .rx_data (rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_side();
        tx_valid = 1'($urandom);
        tx_data  = AS'($urandom);
    endtask

    // kind 1: deselect for a few cycles; kind 2: synchronous reset. Leaves the DUT in CHK_CMD.
    task automatic abort(input int kind);
        if (kind == 1) begin
            SS_n = 1'b1;
            repeat ($urandom_range(1, 3)) begin
                rand_side();
                MOSI = 1'($urandom);
                tick();
                check("miso_desel", 32'(MISO), 0);
                check("rx_valid_desel", 32'(rx_valid), 0);
                check("rx_data_desel", 32'(rx_data), 32'(m_rx));
            end
        end else begin
            rst  = 1'b1;
            SS_n = 1'($urandom);
            rand_side();
            tick();
            check("miso_rst", 32'(MISO), 0);
            check("rx_valid_rst", 32'(rx_valid), 0);
            check("rx_data_rst", 32'(rx_data), 0);
            m_rx   = '0;
            m_flag = 1'b0;
            rst    = 1'b0;
        end
        SS_n = 1'b0;
        rand_side();
        tick();
        check("miso_reselect", 32'(MISO), 0);
    endtask

    task automatic send_frame(input logic sel, input logic [N-1:0] word);
        logic rd_add;
        rd_add = sel && !m_flag;
        MOSI = sel;
        rand_side();
        tick();
        check("rx_valid_sel", 32'(rx_valid), 0);
        check("miso_sel", 32'(MISO), 0);
        for (int i = N - 1; i >= 0; i--) begin
            MOSI = word[i];
            rand_side();
            tick();
            check("miso_rx", 32'(MISO), 0);
            if (i > 0) begin
                check("rx_valid_early", 32'(rx_valid), 0);
                check("rx_data_hold", 32'(rx_data), 32'(m_rx));
            end else begin
                check("rx_valid_pulse", 32'(rx_valid), 1);
                check("rx_data_word", 32'(rx_data), 32'(word));
            end
        end
        m_rx = word;
        if (rd_add) m_flag = 1'b1;
    endtask

    task automatic partial_frame(input logic sel, input int nbits, input int kind);
        MOSI = sel;
        rand_side();
        tick();
        check("rx_valid_sel", 32'(rx_valid), 0);
        for (int i = 0; i < nbits; i++) begin
            MOSI = 1'($urandom);
            rand_side();
            tick();
            check("rx_valid_partial", 32'(rx_valid), 0);
            check("rx_data_partial", 32'(rx_data), 32'(m_rx));
            check("miso_partial", 32'(MISO), 0);
        end
        abort(kind);
    endtask

    // Read-data phase: wait_n idle cycles, then byte b out on MISO. With kind != 0 the transfer
    // is aborted after 'cut' MISO bits have been presented.
    task automatic read_phase(input int wait_n, input logic [AS-1:0] b, input int cut,
                              input int kind);
        for (int w = 0; w < wait_n; w++) begin
            tx_valid = 1'b0;
            tx_data  = AS'($urandom);
            MOSI     = 1'($urandom);
            tick();
            check("miso_wait", 32'(MISO), 0);
            check("rx_valid_wait", 32'(rx_valid), 0);
        end
        if (kind != 0 && cut == 0) begin
            abort(kind);
            return;
        end
        tx_valid = 1'b1;
        tx_data  = b;
        tick();
        check("miso_bit", 32'(MISO), 32'(b[AS-1]));
        check("rx_valid_tx", 32'(rx_valid), 0);
        for (int j = 1; j < int'(AS); j++) begin
            if (kind != 0 && cut == j) begin
                abort(kind);
                return;
            end
            rand_side();
            MOSI = 1'($urandom);
            tick();
            check("miso_bit", 32'(MISO), 32'(b[AS-1-j]));
        end
        if (kind != 0 && cut == int'(AS)) begin
            abort(kind);
            return;
        end
        rand_side();
        tick();
        check("miso_end", 32'(MISO), 0);
        m_flag = 1'b0;
    endtask

    initial begin
        int unsigned op;
        logic        sel;
        logic        rd;
        int          kind;

        rst      = 1'b1;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        m_flag   = 1'b0;
        m_rx     = '0;
        tick();
        tick();
        check("reset_rx_data", 32'(rx_data), 0);
        check("reset_rx_valid", 32'(rx_valid), 0);
        check("reset_miso", 32'(MISO), 0);
        rst  = 1'b0;
        SS_n = 1'b0;
        tick();
        check("miso_select", 32'(MISO), 0);

        // Write frame.
        send_frame(1'b0, 10'h0A5);
        // Read address, read data, then C3 returned on MISO.
        send_frame(1'b1, 10'h23C);
        send_frame(1'b1, 10'h300);
        read_phase(3, 8'hC3, 0, 0);
        // Flag cleared: next read select is a read-address frame.
        send_frame(1'b1, 10'h2AA);
        send_frame(1'b0, 10'h155);
        // Abort a write after 5 bits, then a full write.
        partial_frame(1'b0, 5, 1);
        send_frame(1'b0, 10'h0F0);
        // Reset after 3 MISO bits; next read select is a read-address frame again.
        send_frame(1'b1, 10'h3A5);
        read_phase(2, 8'hB6, 3, 2);
        send_frame(1'b1, 10'h211);
        send_frame(1'b1, 10'h35A);
        read_phase(0, 8'h5E, 0, 0);

        for (int it = 0; it < 200; it++) begin
            op  = $urandom_range(0, 19);
            sel = 1'($urandom);
            if (op < 2) begin
                partial_frame(sel, $urandom_range(0, N - 1), 1);
            end else if (op == 2) begin
                partial_frame(sel, $urandom_range(0, N - 1), 2);
            end else begin
                rd = sel && m_flag;
                send_frame(sel, N'($urandom));
                if (rd) begin
                    kind = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
                    read_phase($urandom_range(0, 4), AS'($urandom), $urandom_range(0, AS), kind);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
